// File: rtl/ep0_pkg.sv
// Shared types and constants for the EP0 SETUP parser.
package ep0_pkg;

    localparam int unsigned SETUP_LEN_DEFAULT      = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ACTIVE  = 2'd2
    } ep0State_t;

    // Standard bRequest codes
    localparam logic [7:0] REQ_SET_ADDRESS    = 8'h05;
    localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;

    // Descriptor type codes (high byte of wValue for GET_DESCRIPTOR)
    localparam logic [7:0] DESC_DEVICE        = 8'h01;
    localparam logic [7:0] DESC_CONFIGURATION = 8'h02;
    localparam logic [7:0] DESC_STRING        = 8'h03;
    localparam logic [7:0] DESC_INTERFACE     = 8'h04;
    localparam logic [7:0] DESC_ENDPOINT      = 8'h05;

    typedef struct packed {
        logic        dptd;
        logic [1:0]  reqType;
        logic [4:0]  recipient;
        logic [7:0]  bRequest;
        logic [15:0] wValue;
        logic [15:0] wIndex;
        logic [15:0] wLength;
    } setupReq_t;

    // Multi-byte fields are little-endian on the wire.
    function automatic setupReq_t decodeSetup(input logic [7:0][7:0] b);
        setupReq_t r;
        r.dptd      = b[0][7];
        r.reqType   = b[0][6:5];
        r.recipient = b[0][4:0];
        r.bRequest  = b[1];
        r.wValue    = {b[3], b[2]};
        r.wIndex    = {b[5], b[4]};
        r.wLength   = {b[7], b[6]};
        return r;
    endfunction

endpackage

// File: rtl/ep0_setup_buffer.sv
// SETUP payload staging buffer: write index, saturating count, overflow flag.
// Exposes next-cycle views so a same-cycle end-of-packet sees the final byte.
module ep0_setup_buffer
    import ep0_pkg::*;
#(
    parameter int unsigned LEN = SETUP_LEN_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wrEn,
    input  logic [7:0]                   wrData,
    output logic [LEN-1:0][7:0]          dataNext_c,
    output logic [$clog2(LEN+1)-1:0]     countNext_c,
    output logic                         overflowNext_c
);

    localparam int unsigned CW = $clog2(LEN + 1);
    localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [LEN-1:0][7:0] mem;
    logic [CW-1:0]       count;
    logic                overflow;

    // Clear beats write; a byte past LEN is dropped and flagged.
    always_comb begin
        dataNext_c     = mem;
        countNext_c    = count;
        overflowNext_c = overflow;
        if (clear) begin
            countNext_c    = '0;
            overflowNext_c = 1'b0;
        end else if (wrEn) begin
            if (count == CW'(LEN)) begin
                overflowNext_c = 1'b1;
            end else begin
                dataNext_c[IW'(count)] = wrData;
                countNext_c            = count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            mem      <= dataNext_c;
            count    <= countNext_c;
            overflow <= overflowNext_c;
        end
    end

endmodule

// File: rtl/ep0_setup_parser.sv
// EP0 SETUP collector/decoder; holds requestValid for the whole control transfer.
// Optional COLLECT timeout enabled by defining EP0_SETUP_TIMEOUT_EN.
module ep0_setup_parser
    import ep0_pkg::*;
#(
    parameter int unsigned SETUP_LEN      = SETUP_LEN_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        setupToken,
    input  logic [7:0]  rxByte,
    input  logic        rxByteValid,
    input  logic        rxPacketEnd,
    input  logic        rxCrcOk,
    input  logic        statusDone,
    output logic        setupAck,
    output logic        setupErr,
    output logic        clearRequest,
    output logic        requestValid,
    output logic        bmRequestTypeDPTD,
    output logic [1:0]  bmRequestTypeType,
    output logic [4:0]  bmRequestTypeRecipient,
    output logic [7:0]  bRequest,
    output logic [15:0] wValue,
    output logic [15:0] wIndex,
    output logic [15:0] wLength
);

    localparam int unsigned CW = $clog2(SETUP_LEN + 1);

    ep0State_t                 state;
    setupReq_t                 req;
    logic [SETUP_LEN-1:0][7:0] bufNext_c;
    logic [CW-1:0]             countNext_c;
    logic                      overflowNext_c;
    logic                      acceptNow_c;
    logic                      timeoutHit_c;

    ep0_setup_buffer #(
        .LEN (SETUP_LEN)
    ) u_buffer (
        .clk            (clk),
        .reset          (reset),
        .clear          (setupToken),
        .wrEn           (rxByteValid && (state == COLLECT)),
        .wrData         (rxByte),
        .dataNext_c     (bufNext_c),
        .countNext_c    (countNext_c),
        .overflowNext_c (overflowNext_c)
    );

    assign acceptNow_c = (countNext_c == CW'(SETUP_LEN)) && rxCrcOk && !overflowNext_c;

`ifdef EP0_SETUP_TIMEOUT_EN
    logic [15:0] timer;

    assign timeoutHit_c = (state == COLLECT) && (timer == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (setupToken) begin
            timer <= '0;
        end else if (state == COLLECT) begin
            timer <= timer + 16'd1;
        end
    end
`else
    logic [31:0] unusedTimeoutCycles;

    assign unusedTimeoutCycles = 32'(TIMEOUT_CYCLES);
    assign timeoutHit_c        = 1'b0;
`endif

    // A new SETUP token overrides everything, including a same-cycle packet end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req          <= '0;
            setupAck     <= 1'b0;
            setupErr     <= 1'b0;
            clearRequest <= 1'b0;
            requestValid <= 1'b0;
        end else begin
            setupAck     <= 1'b0;
            setupErr     <= 1'b0;
            clearRequest <= 1'b0;
            if (setupToken) begin
                state        <= COLLECT;
                requestValid <= 1'b0;
                clearRequest <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (rxPacketEnd) begin
                            if (acceptNow_c) begin
                                req          <= decodeSetup(bufNext_c[7:0]);
                                requestValid <= 1'b1;
                                setupAck     <= 1'b1;
                                state        <= ACTIVE;
                            end else begin
                                setupErr <= 1'b1;
                                state    <= IDLE;
                            end
                        end else if (timeoutHit_c) begin
                            setupErr <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    ACTIVE: begin
                        if (statusDone) begin
                            requestValid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bmRequestTypeDPTD      = req.dptd;
    assign bmRequestTypeType      = req.reqType;
    assign bmRequestTypeRecipient = req.recipient;
    assign bRequest               = req.bRequest;
    assign wValue                 = req.wValue;
    assign wIndex                 = req.wIndex;
    assign wLength                = req.wLength;

endmodule

// File: tb/tb_ep0_setup_parser.sv
// Bench for ep0_setup_parser: directed plus randomized packets against a transaction-level model.
module tb_ep0_setup_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        setupToken, rxByteValid, rxPacketEnd, rxCrcOk, statusDone;
    logic [7:0]  rxByte;
    logic        setupAck, setupErr, clearRequest, requestValid;
    logic        bmRequestTypeDPTD;
    logic [1:0]  bmRequestTypeType;
    logic [4:0]  bmRequestTypeRecipient;
    logic [7:0]  bRequest;
    logic [15:0] wValue, wIndex, wLength;

    int checks = 0;
    int errors = 0;

    logic [7:0] expBytes [8];
    bit         modelActive;
    logic [7:0] q [$];

    ep0_setup_parser dut (
        .clk                    (clk),
        .reset                  (reset),
        .setupToken             (setupToken),
        .rxByte                 (rxByte),
        .rxByteValid            (rxByteValid),
        .rxPacketEnd            (rxPacketEnd),
        .rxCrcOk                (rxCrcOk),
        .statusDone             (statusDone),
        .setupAck               (setupAck),
        .setupErr               (setupErr),
        .clearRequest           (clearRequest),
        .requestValid           (requestValid),
        .bmRequestTypeDPTD      (bmRequestTypeDPTD),
        .bmRequestTypeType      (bmRequestTypeType),
        .bmRequestTypeRecipient (bmRequestTypeRecipient),
        .bRequest               (bRequest),
        .wValue                 (wValue),
        .wIndex                 (wIndex),
        .wLength                (wLength)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fieldsObs();
        return {bmRequestTypeDPTD, bmRequestTypeType, bmRequestTypeRecipient,
                bRequest, wValue, wIndex, wLength};
    endfunction

    // Little-endian 16-bit words built arithmetically from the wire bytes
    function automatic logic [63:0] fieldsExp();
        return {expBytes[0], expBytes[1],
                16'(expBytes[2] + 256 * expBytes[3]),
                16'(expBytes[4] + 256 * expBytes[5]),
                16'(expBytes[6] + 256 * expBytes[7])};
    endfunction

    function automatic logic [63:0] pulses();
        return 64'({setupAck, setupErr, clearRequest, requestValid});
    endfunction

    function automatic logic [63:0] pexp(input bit a, input bit e, input bit c, input bit v);
        return 64'({a, e, c, v});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        setupToken  = 1'b0;
        rxByteValid = 1'b0;
        rxPacketEnd = 1'b0;
        rxCrcOk     = 1'b0;
        statusDone  = 1'b0;
        rxByte      = 8'($urandom);
    endtask

    task automatic token(input bit withStatus);
        setupToken = 1'b1;
        statusDone = withStatus;
        step();
        clearInputs();
        modelActive = 1'b0;
        chk("token_pulses", pulses(), pexp(0, 0, 1, 0));
        chk("token_fields_hold", fieldsObs(), fieldsExp());
    endtask

    task automatic status(input string tag);
        statusDone = 1'b1;
        step();
        clearInputs();
        modelActive = 1'b0;
        chk(tag, pulses(), pexp(0, 0, 0, 0));
    endtask

    // live: parser is expected to be collecting (after a token)
    task automatic sendPacket(input string tag, input bit live, input bit crc, input bit merge);
        bit accept;
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rxCrcOk = 1'($urandom);
                step();
            end
            rxByteValid = 1'b1;
            rxByte      = q[i];
            rxCrcOk     = 1'($urandom);
            if (merge && (i == n - 1)) begin
                rxPacketEnd = 1'b1;
                rxCrcOk     = crc;
            end
            step();
            clearInputs();
        end
        if (!merge) begin
            rxPacketEnd = 1'b1;
            rxCrcOk     = crc;
            step();
            clearInputs();
        end
        accept = live && (n == 8) && crc;
        if (accept) begin
            for (int i = 0; i < 8; i++) expBytes[i] = q[i];
            modelActive = 1'b1;
        end
        if (live) begin
            chk({tag, "_end"}, pulses(), pexp(accept, !accept, 0, accept));
            if (!accept) modelActive = 1'b0;
        end else begin
            chk({tag, "_ignored"}, pulses(), pexp(0, 0, 0, modelActive));
        end
        chk({tag, "_fields"}, fieldsObs(), fieldsExp());
        step();
        chk({tag, "_after"}, pulses(), pexp(0, 0, 0, modelActive));
    endtask

    task automatic randBytes(input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    initial begin
        clearInputs();
        for (int i = 0; i < 8; i++) expBytes[i] = 8'h00;
        modelActive = 1'b0;
        reset = 1'b0;
        step();
        step();
        chk("reset_pulses", pulses(), pexp(0, 0, 0, 0));
        chk("reset_fields", fieldsObs(), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // GET_DESCRIPTOR(device)
        token(1'b0);
        q = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h00};
        sendPacket("getdesc", 1'b1, 1'b1, 1'b0);
        chk("getdesc_dptd", 64'(bmRequestTypeDPTD), 64'h1);
        chk("getdesc_type", 64'({bmRequestTypeType, bmRequestTypeRecipient}), 64'h0);
        chk("getdesc_breq", 64'(bRequest), 64'h06);
        chk("getdesc_wvalue", 64'(wValue), 64'h0100);
        chk("getdesc_windex", 64'(wIndex), 64'h0);
        chk("getdesc_wlength", 64'(wLength), 64'h0012);
        status("status_active");
        status("status_idle_ignored");

        // Short, long, bad-CRC packets
        token(1'b0);
        randBytes(7);
        sendPacket("short", 1'b1, 1'b1, 1'b0);
        token(1'b0);
        randBytes(9);
        sendPacket("long", 1'b1, 1'b1, 1'b0);
        token(1'b0);
        randBytes(8);
        sendPacket("badcrc", 1'b1, 1'b0, 1'b1);
        randBytes(8);
        sendPacket("idle_bytes", 1'b0, 1'b1, 1'b0);

        // SET_ADDRESS, ignored data stage, then override
        token(1'b0);
        q = {8'h00, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendPacket("setaddr", 1'b1, 1'b1, 1'b1);
        chk("setaddr_wvalue", 64'(wValue), 64'h0007);
        randBytes(8);
        sendPacket("active_bytes", 1'b0, 1'b1, 1'b0);
        token(1'b1);
        randBytes(8);
        sendPacket("override", 1'b1, 1'b1, 1'b0);

        // Token and packet end in the same cycle: token wins and restarts the count
        token(1'b0);
        for (int i = 0; i < 8; i++) begin
            rxByteValid = 1'b1;
            rxByte      = 8'($urandom);
            step();
            clearInputs();
        end
        setupToken  = 1'b1;
        rxPacketEnd = 1'b1;
        rxCrcOk     = 1'b1;
        step();
        clearInputs();
        chk("token_vs_end", pulses(), pexp(0, 0, 1, 0));
        randBytes(8);
        sendPacket("after_token_end", 1'b1, 1'b1, 1'b1);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            int n;
            if (modelActive && $urandom_range(0, 1) == 1) status("rand_status");
            token(1'($urandom));
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 10)) : 8;
            randBytes(n);
            sendPacket("rand", 1'b1, ($urandom_range(0, 4) != 0), 1'($urandom));
        end

        // Asynchronous reset in the middle of COLLECT
        token(1'b0);
        for (int i = 0; i < 3; i++) begin
            rxByteValid = 1'b1;
            rxByte      = 8'($urandom);
            step();
            clearInputs();
        end
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) expBytes[i] = 8'h00;
        modelActive = 1'b0;
        chk("async_reset_pulses", pulses(), pexp(0, 0, 0, 0));
        chk("async_reset_fields", fieldsObs(), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        randBytes(8);
        sendPacket("post_reset_idle", 1'b0, 1'b1, 1'b0);
        token(1'b0);
        randBytes(8);
        sendPacket("post_reset", 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
